// File: rtl/vga_pkg.sv
// Shared VGA types and constants: colour type, named colours, standard
// 640x480@60 timing values and the per-axis raster state encoding.
package vga_pkg;

  typedef logic [5:0] color_t;

  localparam color_t BLACK = 6'b000000;
  localparam color_t RED   = 6'b110000;
  localparam color_t WHITE = 6'b111111;

  // Standard 640x480@60 timing (pixels per line, lines per frame).
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  // Raw state codes kept as plain constants so older tools/netlists can match them.
  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  typedef enum logic [1:0] {
    ACTIVE = ST_ACTIVE,
    FRONT  = ST_FRONT,
    SYNC   = ST_SYNC,
    BACK   = ST_BACK
  } axis_state_e;

  // True when a visible pixel lies on the outer edge of the active window.
  function automatic logic on_border(logic [9:0] col, logic [9:0] row,
                                     logic [9:0] last_col, logic [9:0] last_row);
    return (col == 10'd0) || (col == last_col) || (row == 10'd0) || (row == last_row);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
// Used for the horizontal axis (advances every pixel) and the vertical axis
// (advances once per line).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LEN_ACTIVE = VGA_H_ACTIVE,
  parameter int LEN_FRONT  = VGA_H_FRONT,
  parameter int LEN_SYNC   = VGA_H_SYNC,
  parameter int LEN_BACK   = VGA_H_BACK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [9:0]  count,
  output axis_state_e state,
  output logic        wrap
);

  localparam int         TOTAL      = LEN_ACTIVE + LEN_FRONT + LEN_SYNC + LEN_BACK;
  localparam logic [9:0] END_ACTIVE = 10'(LEN_ACTIVE - 1);
  localparam logic [9:0] END_FRONT  = 10'(LEN_ACTIVE + LEN_FRONT - 1);
  localparam logic [9:0] END_SYNC   = 10'(LEN_ACTIVE + LEN_FRONT + LEN_SYNC - 1);
  localparam logic [9:0] END_BACK   = 10'(TOTAL - 1);

  logic [9:0]  count_q, count_d;
  axis_state_e state_q, state_d;

  // Next position and region: move on when the last position of a region is reached.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (advance) begin
      count_d = (count_q == END_BACK) ? 10'd0 : count_q + 10'd1;
      case (state_q)
        ACTIVE:  if (count_q == END_ACTIVE) state_d = FRONT;
        FRONT:   if (count_q == END_FRONT)  state_d = SYNC;
        SYNC:    if (count_q == END_SYNC)   state_d = BACK;
        BACK:    if (count_q == END_BACK)   state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end
  end

  // Position/region registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 10'd0;
      state_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign wrap  = (count_q == END_BACK);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster source: pixel prescaler, H/V axis counters, and a one-pixel
// output stage that blanks colour and aligns hsync/vsync with it.
// Optional build macro VGA_BORDER_EN: draw a white frame on the outermost
// active rows/columns instead of color_in.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 1,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FRONT  = VGA_H_FRONT,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BACK   = VGA_H_BACK,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FRONT  = VGA_V_FRONT,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BACK   = VGA_V_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] color_in,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] color
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pix_tick_q, pix_tick_d;
  logic          frame_start_q, frame_start_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  color_t        color_q, color_d;

  logic [9:0]  col, row;
  axis_state_e h_state, v_state;
  logic        h_wrap, v_wrap;
  logic        in_active;

  vga_axis_counter #(
    .LEN_ACTIVE(H_ACTIVE), .LEN_FRONT(H_FRONT), .LEN_SYNC(H_SYNC), .LEN_BACK(H_BACK)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .advance(pix_tick_q),
    .count(col), .state(h_state), .wrap(h_wrap)
  );

  // Vertical axis steps once per line, on the tick that wraps the column.
  vga_axis_counter #(
    .LEN_ACTIVE(V_ACTIVE), .LEN_FRONT(V_FRONT), .LEN_SYNC(V_SYNC), .LEN_BACK(V_BACK)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .advance(pix_tick_q && h_wrap),
    .count(row), .state(v_state), .wrap(v_wrap)
  );

  assign in_active = (h_state == ACTIVE) && (v_state == ACTIVE);

  // Prescaler: pix_tick is registered so it is low in reset even when CLK_DIV=1.
  always_comb begin
    pix_tick_d = (pre_q == PRE_LAST);
    pre_d      = pix_tick_d ? '0 : pre_q + PW'(1);
  end

  // Output stage: sample colour and sync levels of the current pixel on its tick.
  always_comb begin
    color_d = color_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_tick_q) begin
      color_d = in_active ? color_in : BLACK;
`ifdef VGA_BORDER_EN
      if (in_active && on_border(col, row, 10'(H_ACTIVE - 1), 10'(V_ACTIVE - 1)))
        color_d = WHITE;
`endif
      hsync_d = (h_state == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (v_state == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
    // Next cycle is a tick at (0,0): either both axes wrap now, or we are parked at (0,0).
    frame_start_d = pix_tick_d &&
                    (pix_tick_q ? (h_wrap && v_wrap) : ((col == 10'd0) && (row == 10'd0)));
  end

  // Prescaler and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      color_q       <= BLACK;
    end else begin
      pre_q         <= pre_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      color_q       <= color_d;
    end
  end

  assign colPos      = col;
  assign rowPos      = row;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign color       = color_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster at CLK_DIV=1 and CLK_DIV=2, plus a
// scaled-down raster (15x8, active-high sync) for whole-frame behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HT = 800, VT = 525;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2, SHT = 15;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1, SVT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] ci_a = 6'd0, ci_b = 6'd0, ci_s = 6'd0;
  logic [9:0] col_a, row_a, col_b, row_b, col_s, row_s;
  logic tick_a, fs_a, hs_a, vs_a, tick_b, fs_b, hs_b, vs_b, tick_s, fs_s, hs_s, vs_s;
  logic [5:0] color_a, color_b, color_s;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [7:0] q_a[$], q_b[$], q_s[$];

  always #5 clk = ~clk;

  // Cycles since reset release; cycle 0 is the one right after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .color_in(ci_a), .colPos(col_a), .rowPos(row_a),
    .pix_tick(tick_a), .frame_start(fs_a), .hsync(hs_a), .vsync(vs_a), .color(color_a)
  );

  vga_timing_gen #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .color_in(ci_b), .colPos(col_b), .rowPos(row_b),
    .pix_tick(tick_b), .frame_start(fs_b), .hsync(hs_b), .vsync(vs_b), .color(color_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .color_in(ci_s), .colPos(col_s), .rowPos(row_s),
    .pix_tick(tick_s), .frame_start(fs_s), .hsync(hs_s), .vsync(vs_s), .color(color_s)
  );

  function automatic bit tick_at(int k, int div);
    return (k > 0) && (k % div == 0);
  endfunction

  function automatic int ticks_before(int k, int div);
    return (k == 0) ? 0 : (k - 1) / div;
  endfunction

  // Expected {hsync, vsync, color} for a pixel, from region ranges.
  function automatic logic [7:0] exp_out(int col, int row, logic [5:0] ci,
                                         int ha, int hf, int hsw, int va, int vf, int vsw,
                                         logic pol);
    logic act;
    logic [5:0] c;
    logic hs, vs;
    act = (col < ha) && (row < va);
    c = act ? ci : 6'd0;
`ifdef VGA_BORDER_EN
    if (act && (col == 0 || col == ha - 1 || row == 0 || row == va - 1)) c = 6'h3f;
`endif
    hs = (col >= ha + hf && col < ha + hf + hsw) ? pol : ~pol;
    vs = (row >= va + vf && row < va + vf + vsw) ? pol : ~pol;
    return {hs, vs, c};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({col_a, row_a, tick_a, fs_a, hs_a, vs_a, color_a} !== {22'd0, 2'b11, 6'd0}) begin
      errors++;
      $display("FAIL reset_a got col=%0d row=%0d tick=%b fs=%b hs=%b vs=%b color=%b want 0 0 0 0 1 1 000000",
               col_a, row_a, tick_a, fs_a, hs_a, vs_a, color_a);
    end
    checks++;
    if ({col_b, row_b, tick_b, fs_b, hs_b, vs_b, color_b} !== {22'd0, 2'b11, 6'd0}) begin
      errors++;
      $display("FAIL reset_b got col=%0d row=%0d tick=%b fs=%b hs=%b vs=%b color=%b want 0 0 0 0 1 1 000000",
               col_b, row_b, tick_b, fs_b, hs_b, vs_b, color_b);
    end
    checks++;
    if ({col_s, row_s, tick_s, fs_s, hs_s, vs_s, color_s} !== {22'd0, 2'b00, 6'd0}) begin
      errors++;
      $display("FAIL reset_s got col=%0d row=%0d tick=%b fs=%b hs=%b vs=%b color=%b want 0 0 0 0 0 0 000000",
               col_s, row_s, tick_s, fs_s, hs_s, vs_s, color_s);
    end
    rst_n = 1'b1;
    $display("reset: released at %0t", $time);
  endtask

  // Full-size raster, CLK_DIV=1, constant fill colour; must start at k<=800.
  task automatic test_raster(input logic [5:0] fill, input int ncyc);
    int k, cnt, ecol, erow, hs_low, fill_cnt, first_low, exp_fill;
    logic [7:0] e;
    q_a.delete();
    hs_low = 0; fill_cnt = 0; first_low = -1;
    ci_a = fill;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      k = cyc;
      cnt = ticks_before(k, 1);
      ecol = cnt % HT;
      erow = (cnt / HT) % VT;
      checks++;
      if (col_a !== 10'(ecol) || row_a !== 10'(erow)) begin
        errors++;
        $display("FAIL raster_pos k=%0d got col=%0d row=%0d want col=%0d row=%0d", k, col_a, row_a, ecol, erow);
      end
      checks++;
      if ({tick_a, fs_a} !== {tick_at(k, 1), tick_at(k, 1) && ecol == 0 && erow == 0}) begin
        errors++;
        $display("FAIL raster_tick k=%0d got tick=%b fs=%b want tick=%b fs=%b", k, tick_a, fs_a,
                 tick_at(k, 1), tick_at(k, 1) && ecol == 0 && erow == 0);
      end
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        checks++;
        if ({hs_a, vs_a, color_a} !== e) begin
          errors++;
          $display("FAIL raster_out k=%0d got hs=%b vs=%b color=%b want hs=%b vs=%b color=%b",
                   k, hs_a, vs_a, color_a, e[7], e[6], e[5:0]);
        end
      end
      if (row_a == 10'd1) begin
        if (hs_a === 1'b0) begin
          hs_low++;
          if (first_low < 0) first_low = int'(col_a);
        end
        if (color_a === fill) fill_cnt++;
      end
      if (tick_at(k, 1)) q_a.push_back(exp_out(ecol, erow, ci_a, 640, 16, 96, 480, 10, 2, 1'b0));
    end
`ifdef VGA_BORDER_EN
    exp_fill = 638;
`else
    exp_fill = 640;
`endif
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_width got %0d want 96", hs_low);
    end
    checks++;
    if (first_low != 657) begin
      errors++;
      $display("FAIL hsync_start_col got %0d want 657", first_low);
    end
    checks++;
    if (fill_cnt != exp_fill) begin
      errors++;
      $display("FAIL active_fill got %0d want %0d", fill_cnt, exp_fill);
    end
    $display("raster: fill=%b hsync_low=%0d fill_pixels=%0d", fill, hs_low, fill_cnt);
  endtask

  // Full-size raster at CLK_DIV=2 with random colour.
  task automatic test_clk_div2(input int ncyc);
    int k, cnt, ecol, erow, row2_cyc;
    logic [7:0] e;
    q_b.delete();
    row2_cyc = 0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      k = cyc;
      cnt = ticks_before(k, 2);
      ecol = cnt % HT;
      erow = (cnt / HT) % VT;
      checks++;
      if (col_b !== 10'(ecol) || row_b !== 10'(erow) || tick_b !== tick_at(k, 2)) begin
        errors++;
        $display("FAIL div2_pos k=%0d got col=%0d row=%0d tick=%b want col=%0d row=%0d tick=%b",
                 k, col_b, row_b, tick_b, ecol, erow, tick_at(k, 2));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        checks++;
        if ({hs_b, vs_b, color_b} !== e) begin
          errors++;
          $display("FAIL div2_out k=%0d got hs=%b vs=%b color=%b want hs=%b vs=%b color=%b",
                   k, hs_b, vs_b, color_b, e[7], e[6], e[5:0]);
        end
      end
      if (row_b == 10'd2) row2_cyc++;
      ci_b = 6'($urandom_range(0, 63));
      if (tick_at(k, 2)) q_b.push_back(exp_out(ecol, erow, ci_b, 640, 16, 96, 480, 10, 2, 1'b0));
    end
    checks++;
    if (row2_cyc != 1600) begin
      errors++;
      $display("FAIL div2_line_clks got %0d want 1600", row2_cyc);
    end
    $display("clk_div2: line=%0d clk", row2_cyc);
  endtask

  // Scaled raster: whole frames, vsync, frame_start period, border pixels.
  task automatic test_frame_small;
    int k, cnt, ecol, erow, last_fs, n_fs, vs_cnt, white_cnt, exp_white;
    logic [7:0] e;
    q_s.delete();
    last_fs = -1; n_fs = 0; vs_cnt = 0; white_cnt = 0;
    ci_s = 6'd0;
    for (int i = 0; i < 3 * SHT * SVT; i++) begin
      @(posedge clk);
      #1;
      k = cyc;
      cnt = ticks_before(k, 1);
      ecol = cnt % SHT;
      erow = (cnt / SHT) % SVT;
      checks++;
      if (col_s !== 10'(ecol) || row_s !== 10'(erow)) begin
        errors++;
        $display("FAIL small_pos k=%0d got col=%0d row=%0d want col=%0d row=%0d", k, col_s, row_s, ecol, erow);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        checks++;
        if ({hs_s, vs_s, color_s} !== e) begin
          errors++;
          $display("FAIL small_out k=%0d got hs=%b vs=%b color=%b want hs=%b vs=%b color=%b",
                   k, hs_s, vs_s, color_s, e[7], e[6], e[5:0]);
        end
      end
      if (fs_s === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs != SHT * SVT) begin
            errors++;
            $display("FAIL frame_period got %0d want %0d", k - last_fs, SHT * SVT);
          end
        end
        last_fs = k;
      end
      if (i < SHT * SVT) begin
        if (vs_s === 1'b1) vs_cnt++;
        if (color_s === 6'h3f) white_cnt++;
      end else begin
        ci_s = 6'($urandom_range(0, 63));
      end
      if (tick_at(k, 1)) q_s.push_back(exp_out(ecol, erow, ci_s, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1));
    end
`ifdef VGA_BORDER_EN
    exp_white = 2 * SHA + 2 * (SVA - 2);
`else
    exp_white = 0;
`endif
    checks++;
    if (n_fs != 3) begin
      errors++;
      $display("FAIL frame_pulses got %0d want 3", n_fs);
    end
    checks++;
    if (vs_cnt != SVS * SHT) begin
      errors++;
      $display("FAIL vsync_width got %0d want %0d", vs_cnt, SVS * SHT);
    end
    checks++;
    if (white_cnt != exp_white) begin
      errors++;
      $display("FAIL border_pixels got %0d want %0d", white_cnt, exp_white);
    end
    $display("frame_small: pulses=%0d vsync_clk=%0d border=%0d", n_fs, vs_cnt, white_cnt);
  endtask

  // Async reset inside hsync; outputs must clear without a clock edge.
  task automatic test_async_reset;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (col_a !== 10'd700 && n < 2000);
    checks++;
    if (col_a !== 10'd700) begin
      errors++;
      $display("FAIL wait_col700 got col=%0d want 700", col_a);
    end
    checks++;
    if (hs_a !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_hsync got %b want 0", hs_a);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({col_a, row_a, tick_a, fs_a, hs_a, vs_a, color_a} !== {22'd0, 2'b11, 6'd0}) begin
      errors++;
      $display("FAIL async_reset_a got col=%0d row=%0d tick=%b fs=%b hs=%b vs=%b color=%b want 0 0 0 0 1 1 000000",
               col_a, row_a, tick_a, fs_a, hs_a, vs_a, color_a);
    end
    checks++;
    if ({col_s, row_s, tick_s, hs_s, vs_s, color_s} !== {21'd0, 2'b00, 6'd0}) begin
      errors++;
      $display("FAIL async_reset_s got col=%0d row=%0d tick=%b hs=%b vs=%b color=%b want 0 0 0 0 0 000000",
               col_s, row_s, tick_s, hs_s, vs_s, color_s);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("async_reset: asserted at col 700 after %0d cycles, released", n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raster(RED, 1700);
    test_clk_div2(3300);
    test_frame_small();
    test_async_reset();
    test_raster(6'b001100, 1700);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
